// File: rtl/tone_synth.sv
`default_nettype none
// ============================================================================
// Module   : tone_synth
// Brief    : Square-wave buzzer driver. Pitch changes only on half-period
//            boundaries, with a silent articulation gap between notes.
// Revision : 1.0
// ============================================================================
module tone_synth #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int GAP_CYCLES = 1_000_000,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       note_in,
    input  logic [1:0]       octave_in,
    input  logic             mute,
    output logic             speaker,
    output logic             playing,
    output logic [3:0]       cur_note,
    output logic [1:0]       cur_octave
);

    typedef enum logic [1:0] {
        S_SILENT = 2'd0,
        S_PLAY   = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    // Middle-octave half periods, CLK_FREQ/(2f) rounded to nearest.
    localparam logic [CNT_W-1:0] c_H_DO = CNT_W'((CLK_FREQ + 262) / 524);
    localparam logic [CNT_W-1:0] c_H_RE = CNT_W'((CLK_FREQ + 294) / 588);
    localparam logic [CNT_W-1:0] c_H_MI = CNT_W'((CLK_FREQ + 330) / 660);
    localparam logic [CNT_W-1:0] c_H_FA = CNT_W'((CLK_FREQ + 349) / 698);
    localparam logic [CNT_W-1:0] c_H_SO = CNT_W'((CLK_FREQ + 392) / 784);
    localparam logic [CNT_W-1:0] c_H_LA = CNT_W'((CLK_FREQ + 440) / 880);
    localparam logic [CNT_W-1:0] c_H_SI = CNT_W'((CLK_FREQ + 494) / 988);
    localparam logic [CNT_W-1:0] c_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    logic [3:0]       r_note_q;
    logic [1:0]       r_oct_q;
    logic             r_mute_q;

    state_t           r_state,   w_state;
    logic [CNT_W-1:0] r_cnt,     w_cnt;
    logic [CNT_W-1:0] r_gap,     w_gap;
    logic [CNT_W-1:0] r_half,    w_half;
    logic             r_speaker, w_speaker;
    logic             r_playing, w_playing;
    logic [3:0]       r_cur_note, w_cur_note;
    logic [1:0]       r_cur_oct,  w_cur_oct;

    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_target_half;
    logic             w_valid;
    logic             w_same;
    logic             w_boundary;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_note_q <= 4'd0;
            r_oct_q  <= 2'd0;
            r_mute_q <= 1'b0;
        end else begin
            r_note_q <= note_in;
            r_oct_q  <= octave_in;
            r_mute_q <= mute;
        end
    end

    always_comb begin
        w_base = '0;
        case (r_note_q)
            4'd1:    w_base = c_H_DO;
            4'd2:    w_base = c_H_RE;
            4'd3:    w_base = c_H_MI;
            4'd4:    w_base = c_H_FA;
            4'd5:    w_base = c_H_SO;
            4'd6:    w_base = c_H_LA;
            4'd7:    w_base = c_H_SI;
            default: w_base = '0;
        endcase
        case (r_oct_q)
            2'd0:    w_target_half = w_base << 1;
            2'd1:    w_target_half = w_base;
            2'd2:    w_target_half = w_base >> 1;
            default: w_target_half = w_base >> 2;
        endcase
    end

    assign w_valid    = (r_note_q != 4'd0) && (r_note_q <= 4'd7) && !r_mute_q;
    assign w_same     = (r_note_q == r_cur_note) && (r_oct_q == r_cur_oct);
    assign w_boundary = (r_cnt == r_half - 1'b1);

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_gap      = r_gap;
        w_half     = r_half;
        w_speaker  = r_speaker;
        w_cur_note = r_cur_note;
        w_cur_oct  = r_cur_oct;

        case (r_state)
            S_SILENT: begin
                w_speaker  = 1'b0;
                w_cur_note = 4'd0;
                w_cur_oct  = 2'd0;
                if (w_valid) begin
                    w_state    = S_PLAY;
                    w_half     = w_target_half;
                    w_cnt      = '0;
                    w_speaker  = 1'b1;
                    w_cur_note = r_note_q;
                    w_cur_oct  = r_oct_q;
                end
            end

            S_PLAY: begin
                if (r_mute_q) begin
                    w_state    = S_SILENT;
                    w_speaker  = 1'b0;
                    w_cur_note = 4'd0;
                    w_cur_oct  = 2'd0;
                end else if (w_boundary) begin
                    w_cnt = '0;
                    if (!w_valid) begin
                        w_state    = S_SILENT;
                        w_speaker  = 1'b0;
                        w_cur_note = 4'd0;
                        w_cur_oct  = 2'd0;
                    end else if (!w_same) begin
                        w_state    = S_GAP;
                        w_speaker  = 1'b0;
                        w_gap      = '0;
                        w_cur_note = 4'd0;
                        w_cur_oct  = 2'd0;
                    end else begin
                        w_speaker = ~r_speaker;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            S_GAP: begin
                w_speaker = 1'b0;
                if (r_mute_q) begin
                    w_state = S_SILENT;
                end else if (r_gap == c_GAP_LAST) begin
                    // Gap end behaves like a fresh note-on from SILENT.
                    if (w_valid) begin
                        w_state    = S_PLAY;
                        w_half     = w_target_half;
                        w_cnt      = '0;
                        w_speaker  = 1'b1;
                        w_cur_note = r_note_q;
                        w_cur_oct  = r_oct_q;
                    end else begin
                        w_state = S_SILENT;
                    end
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end

            default: begin
                w_state    = S_SILENT;
                w_speaker  = 1'b0;
                w_cur_note = 4'd0;
                w_cur_oct  = 2'd0;
            end
        endcase

        w_playing = (w_state == S_PLAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_SILENT;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_half     <= '0;
            r_speaker  <= 1'b0;
            r_playing  <= 1'b0;
            r_cur_note <= 4'd0;
            r_cur_oct  <= 2'd0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_gap      <= w_gap;
            r_half     <= w_half;
            r_speaker  <= w_speaker;
            r_playing  <= w_playing;
            r_cur_note <= w_cur_note;
            r_cur_oct  <= w_cur_oct;
        end
    end

    assign speaker    = r_speaker;
    assign playing    = r_playing;
    assign cur_note   = r_cur_note;
    assign cur_octave = r_cur_oct;

endmodule
`default_nettype wire

// File: tb/tb_tone_synth.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_synth
// Brief    : Directed bench for tone_synth at a 1 MHz clock scale.
// Revision : 1.0
// ============================================================================
module tb_tone_synth;

    localparam int c_LIMIT = 10000;

    logic       clk;
    logic       reset;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       mute;
    logic       speaker;
    logic       playing;
    logic [3:0] cur_note;
    logic [1:0] cur_octave;

    int checks = 0;
    int errors = 0;
    int n;

    tone_synth #(
        .CLK_FREQ   (1_000_000),
        .GAP_CYCLES (100),
        .CNT_W      (13)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note_in    (note_in),
        .octave_in  (octave_in),
        .mute       (mute),
        .speaker    (speaker),
        .playing    (playing),
        .cur_note   (cur_note),
        .cur_octave (cur_octave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Negedges until speaker leaves its current level (bounded).
    task automatic run_phase(output int len);
        logic start;
        start = speaker;
        len = 0;
        while (speaker == start && len < c_LIMIT) begin
            @(negedge clk);
            len++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        note_in   = 4'd0;
        octave_in = 2'd0;
        mute      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_speaker", speaker, 0);
        check("rst_playing", playing, 0);
        check("rst_cur_note", cur_note, 0);
        check("rst_cur_oct", cur_octave, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // LA, middle octave: H = 1136
        note_in = 4'd6; octave_in = 2'd1;
        @(negedge clk); check("lat1_low", speaker, 0);
        @(negedge clk); check("lat2_high", speaker, 1);
        check("la_playing", playing, 1);
        check("la_note", cur_note, 6);
        check("la_oct", cur_octave, 1);
        for (int i = 0; i < 4; i++) begin
            run_phase(n); check("la_phase", n, 1136);
        end

        // Octave 2: full phase, gap, then 568
        octave_in = 2'd2;
        run_phase(n); check("la_last_high", n, 1136);
        run_phase(n); check("gap_o2", n, 100);
        run_phase(n); check("o2_high", n, 568);
        check("o2_oct", cur_octave, 2);
        run_phase(n); check("o2_low", n, 568);

        // Octave 0: 2272
        octave_in = 2'd0;
        run_phase(n); check("o2_last_high", n, 568);
        run_phase(n); check("gap_o0", n, 100);
        run_phase(n); check("o0_high", n, 2272);

        // Octave 3 requested during a low phase: low 2272 + gap 100, then 284
        octave_in = 2'd3;
        run_phase(n); check("o0_low_gap", n, 2372);
        run_phase(n); check("o3_high", n, 284);

        // DO middle, then SO mid-high-phase
        note_in = 4'd1; octave_in = 2'd1;
        run_phase(n); check("o3_low_gap", n, 384);
        check("do_note", cur_note, 1);
        repeat (500) @(negedge clk);
        note_in = 4'd5;
        run_phase(n); check("do_rest_high", n, 1408);
        run_phase(n); check("gap_so", n, 100);
        run_phase(n); check("so_high", n, 1276);
        check("so_note", cur_note, 5);

        // Out-of-range note: silence at next boundary
        note_in = 4'd9;
        repeat (1275) @(negedge clk);
        check("rest_pre_playing", playing, 1);
        @(negedge clk);
        check("rest_playing", playing, 0);
        check("rest_note", cur_note, 0);
        check("rest_oct", cur_octave, 0);
        check("rest_speaker", speaker, 0);

        // MI with a brief re-press: no gap
        note_in = 4'd3;
        @(negedge clk); check("mi_lat1", speaker, 0);
        @(negedge clk); check("mi_lat2", speaker, 1);
        repeat (10) @(negedge clk);
        note_in = 4'd0;
        @(negedge clk);
        note_in = 4'd3;
        run_phase(n); check("mi_high_rest", n, 1504);
        run_phase(n); check("mi_low_nogap", n, 1515);

        // Mute mid-high phase
        repeat (100) @(negedge clk);
        mute = 1'b1;
        @(negedge clk); check("mute_lat1", speaker, 1);
        @(negedge clk); check("mute_lat2", speaker, 0);
        check("mute_playing", playing, 0);
        mute = 1'b0;
        @(negedge clk); check("unmute_lat1", speaker, 0);
        @(negedge clk); check("unmute_lat2", speaker, 1);
        run_phase(n); check("unmute_high", n, 1515);
        run_phase(n); check("unmute_low", n, 1515);

        // Asynchronous reset mid high phase
        repeat (20) @(negedge clk);
        note_in = 4'd1;
        #2 reset = 1'b0;
        #1;
        check("arst_speaker", speaker, 0);
        check("arst_playing", playing, 0);
        check("arst_note", cur_note, 0);
        check("arst_oct", cur_octave, 0);
        repeat (2) @(negedge clk);
        check("arst_hold_speaker", speaker, 0);
        reset = 1'b1;
        @(negedge clk); check("rel_lat1", speaker, 0);
        @(negedge clk); check("rel_lat2", speaker, 1);
        check("rel_note", cur_note, 1);
        check("rel_oct", cur_octave, 1);
        run_phase(n); check("rel_high", n, 1908);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tone_synth.md
# tone_synth

Downstream audio stage of the piano datapath. Consumes the controller's registered `note_out`/`octave_out` pair and drives the board buzzer with a square wave at the requested pitch. Pitch changes occur only on half-period boundaries, and an articulation gap is inserted between distinct notes, so the buzzer never emits runt pulses or slurs consecutive notes. Reports the pitch currently sounding for display/debug.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock in Hz; sets the half-period table.
- `GAP_CYCLES`, 1_000_000, silence inserted between two different pitches (≥1).
- `CNT_W`, 20, half-period / gap counter width; must hold 2×(CLK_FREQ/524) and GAP_CYCLES.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `note_in`  in  4  note code: 0 = rest, 1..7 = do..si (C..B), 8..15 = rest.
- `octave_in`  in  2  0 = low, 1 = middle, 2 = high, 3 = high+1.
- `mute`  in  1  force silence.
- `speaker`  out  1  square-wave buzzer drive.
- `playing`  out  1  high while in PLAY.
- `cur_note`  out  4  note sounding now; 0 when not in PLAY.
- `cur_octave`  out  2  octave sounding now; 0 when not in PLAY.

## Operation
- Input stage: `note_in`, `octave_in`, `mute` registered into `note_q`, `oct_q`, `mute_q` every cycle. The FSM uses only the registered values.
- Target is valid when `note_q` ∈ 1..7 and `mute_q` = 0.
- Half-period `H` = CLK_FREQ/(2f), rounded to nearest integer.
  - Middle-octave f: 262, 294, 330, 349, 392, 440, 494 Hz.
  - At 100 MHz: 190840, 170068, 151515, 143266, 127551, 113636, 101215.
  - Octave 0 uses H<<1; octave 1 uses H; octave 2 uses H>>1; octave 3 uses H>>2 (truncating).
- `H` is latched into `half_r` when entering PLAY and is constant while in PLAY.
- FSM states:
  - SILENT:
    - `speaker`=0.
    - If the target is valid: load `half_r`, set `cnt`=0, `speaker`=1, capture `cur_note`/`cur_octave`, go to PLAY.
  - PLAY:
    - `cnt` increments each cycle.
    - At `cnt`==`half_r`−1 (boundary), `cnt`←0 and:
      - if the target is invalid (rest or out of range): `speaker`←0, go to SILENT;
      - if the target pitch (note or octave) differs from `cur_*`: `speaker`←0, load `gap`=0, go to GAP;
      - otherwise toggle `speaker`.
    - Exception: `mute_q`=1 in any PLAY cycle immediately drives `speaker`←0 and goes to SILENT, without waiting for a boundary.
  - GAP:
    - `speaker`=0; `gap` increments.
    - At `gap`==GAP_CYCLES−1: if the target is valid, enter PLAY as from SILENT using the target at that cycle; else go to SILENT.
    - `mute_q`=1 goes to SILENT.
- Target changes inside a half-period are ignored until the boundary. Only the value present at the boundary or gap end matters.
- Re-selecting the same pitch never retriggers; the tone continues.
- Reset (any time, including mid-tone): state SILENT; `speaker`, `playing`, `cur_note`, `cur_octave`, `cnt`, `gap`, `half_r` and input registers all 0.

## Timing
- Note-on latency: input changes before edge k, `note_q` updates at k, and `speaker` goes high after edge k+1 (2 cycles).
- Each high or low phase lasts exactly `half_r` cycles. The first high phase is full length.
- Pitch change: the current phase completes, then `speaker` is low for exactly GAP_CYCLES cycles, then the new first high phase starts.
- Rest/note-off: silence begins at the next boundary (≤`half_r` cycles after `note_q` changes).
- Mute latency: 2 cycles from `mute` to `speaker`=0.
- Reset assertion clears outputs asynchronously. Deassertion is sampled on the next `clk` edge.
- Outputs are registered and glitch-free. `playing` equals (state==PLAY).

## Test plan
- Reset, then `note_in`=6, `octave_in`=1 held → `speaker` rises 2 cycles later; phases are 113636 cycles each for ≥4 phases; `playing`=1; `cur_note`=6.
- `note_in`=6, `octave_in`=2 → phases of 56818. Octave 0 → 227272. Octave 3 → 28409.
- With GAP_CYCLES=100, playing 1/oct 1, switch to 5 mid-high-phase:
  - the high phase ends at the full 190840 cycles;
  - `speaker` is low for exactly 100 cycles;
  - then 127551-cycle phases follow, with `cur_note`=5.
- Playing note 3, drive `note_in`=9 → tone stops at the next boundary; SILENT state; `cur_note`=0. Same-note re-press shows no gap.
- Assert `mute` mid-high-phase → `speaker`=0 two cycles later. Release → new tone starts with a full high phase 2 cycles after release.
- Pull `reset` low mid-phase (not on a clock edge) → all outputs 0 immediately. Release with note 1 held → tone restarts cleanly after 2 cycles.
